// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_arb_pkg;

    // Arbiter ownership states: nobody, master 0, master 1.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    // Master that wins a simultaneous request straight after reset.
    localparam logic RST_PRIO = 1'b0;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Stall watchdog: counts cycles a strobe waits without ack/err and flags expiry.
// Latency: expire is combinational on the cycle the count reaches TIMEOUT_CYCLES-1.
// Backpressure: none of its own; the arbiter uses expire to end the stalled strobe.
//
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   active    - a strobe is outstanding on the slave port (cyc & stb)
//   done      - the slave answered this cycle (ack | err)
//   expire    - one-cycle timeout pulse
module wb_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic done,
    output logic expire
);
    import wb_arb_pkg::*;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // A real answer in the final cycle wins over the timeout.
    assign expire = active & ~done & (count == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (!active || done || expire) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/wb_arbiter_2x1.sv
// Two-master, one-slave Wishbone arbiter; round-robin per CYC, grant held until CYC drops.
// Latency: 1 cycle to grant; data phase (ack/err/dat_r) is combinational, 0 cycles.
// Backpressure: a losing master simply waits with cyc high; it sees ack=0/err=0 until granted.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   m0_* / m1_*     - Wishbone slave ports facing instruction (m0) and data (m1) masters
//   s_*             - Wishbone master port facing the shared slave
// Optional build macro WB_ARB_TIMEOUT_EN adds a stall watchdog that ends a hung
// strobe with err after TIMEOUT_CYCLES; without it err is pure pass-through.
module wb_arbiter_2x1 #(
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int WB_DATA_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic [WB_ADDR_WIDTH-1:0]   m0_adr,
    input  logic [WB_DATA_WIDTH-1:0]   m0_dat_w,
    output logic [WB_DATA_WIDTH-1:0]   m0_dat_r,
    input  logic [WB_DATA_WIDTH/8-1:0] m0_sel,
    input  logic                       m0_we,
    input  logic                       m0_cyc,
    input  logic                       m0_stb,
    output logic                       m0_ack,
    output logic                       m0_err,

    input  logic [WB_ADDR_WIDTH-1:0]   m1_adr,
    input  logic [WB_DATA_WIDTH-1:0]   m1_dat_w,
    output logic [WB_DATA_WIDTH-1:0]   m1_dat_r,
    input  logic [WB_DATA_WIDTH/8-1:0] m1_sel,
    input  logic                       m1_we,
    input  logic                       m1_cyc,
    input  logic                       m1_stb,
    output logic                       m1_ack,
    output logic                       m1_err,

    output logic [WB_ADDR_WIDTH-1:0]   s_adr,
    output logic [WB_DATA_WIDTH-1:0]   s_dat_w,
    input  logic [WB_DATA_WIDTH-1:0]   s_dat_r,
    output logic [WB_DATA_WIDTH/8-1:0] s_sel,
    output logic                       s_we,
    output logic                       s_cyc,
    output logic                       s_stb,
    input  logic                       s_ack,
    input  logic                       s_err
);
    import wb_arb_pkg::*;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("wb_arbiter_2x1: TIMEOUT_CYCLES out of range 2..65535");
    end

    arb_state_t state, state_nxt;
    logic       prio, prio_nxt;   // 0: m0 wins a tie in IDLE, 1: m1 wins
    logic       g_stb;            // granted master's stb before watchdog masking
    logic       expire;

    // Arbitration: a grant only ends when its owner drops cyc, and the
    // release hands straight over to a waiting peer to avoid an IDLE bubble.
    always_comb begin
        state_nxt = state;
        prio_nxt  = prio;
        case (state)
            IDLE: begin
                if (m0_cyc && m1_cyc) begin
                    state_nxt = prio ? GNT1 : GNT0;
                end else if (m0_cyc) begin
                    state_nxt = GNT0;
                end else if (m1_cyc) begin
                    state_nxt = GNT1;
                end
            end
            GNT0: begin
                if (!m0_cyc) begin
                    prio_nxt  = 1'b1;
                    state_nxt = m1_cyc ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!m1_cyc) begin
                    prio_nxt  = 1'b0;
                    state_nxt = m0_cyc ? GNT0 : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            prio  <= RST_PRIO;
        end else begin
            state <= state_nxt;
            prio  <= prio_nxt;
        end
    end

    // Slave-side request mux; everything is driven low while nobody owns the bus.
    always_comb begin
        s_adr   = '0;
        s_dat_w = '0;
        s_sel   = '0;
        s_we    = 1'b0;
        s_cyc   = 1'b0;
        g_stb   = 1'b0;
        case (state)
            GNT0: begin
                s_adr   = m0_adr;
                s_dat_w = m0_dat_w;
                s_sel   = m0_sel;
                s_we    = m0_we;
                s_cyc   = m0_cyc;
                g_stb   = m0_stb;
            end
            GNT1: begin
                s_adr   = m1_adr;
                s_dat_w = m1_dat_w;
                s_sel   = m1_sel;
                s_we    = m1_we;
                s_cyc   = m1_cyc;
                g_stb   = m1_stb;
            end
            default: ;
        endcase
    end

`ifdef WB_ARB_TIMEOUT_EN
    wb_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .active (s_cyc & g_stb),
        .done   (s_ack | s_err),
        .expire (expire)
    );
`else
    assign expire = 1'b0;
`endif

    // The strobe is withdrawn in the timeout cycle so the slave does not see
    // a transfer that the master has already been told failed.
    assign s_stb = g_stb & ~expire;

    // Responses reach the owner only; read data is shared and qualified by ack.
    assign m0_ack   = (state == GNT0) & s_ack;
    assign m1_ack   = (state == GNT1) & s_ack;
    assign m0_err   = (state == GNT0) & (s_err | expire);
    assign m1_err   = (state == GNT1) & (s_err | expire);
    assign m0_dat_r = s_dat_r;
    assign m1_dat_r = s_dat_r;

endmodule

// File: doc/wb_arbiter_2x1.md
# wb_arbiter_2x1

Two-master, one-slave Wishbone arbiter. It shares a single slave (for example the boot ROM or SRAM on a reduced SoC) between the CPU instruction bus (m0) and data bus (m1). It grants the slave round-robin at cycle (CYC) granularity and holds the grant until the owning master drops CYC. An optional bus watchdog ends stalled transfers with ERR so that a missing or hung slave cannot deadlock the core.

## Interface
Parameters:
- WB_ADDR_WIDTH, 32: address width of all three ports.
- WB_DATA_WIDTH, 32: data width of all three ports; SEL width is WB_DATA_WIDTH/8.
- TIMEOUT_CYCLES, 256: watchdog limit in cycles; legal range 2..65535. Ignored unless WB_ARB_TIMEOUT_EN is defined.

Ports:
- clk, input, 1: the single clock.
- rst, input, 1: synchronous, active-high reset.
- m0, wb_if.slave, WB_ADDR/DATA: master 0 (instruction bus). Priority winner after reset.
- m1, wb_if.slave, WB_ADDR/DATA: master 1 (data bus).
- s, wb_if.master, WB_ADDR/DATA: the shared slave.
- wb_if fields used: adr, dat_w, dat_r, sel, we, cyc, stb, ack, err.

## Operation
- FSM states: IDLE, GNT0, GNT1. State is registered. Slave-side outputs are combinational muxes of the granted master.
- IDLE:
  - Only m0.cyc high: go to GNT0.
  - Only m1.cyc high: go to GNT1.
  - Both high: grant the master selected by prio (0 selects m0).
  - Neither high: stay in IDLE.
- GNTn: forward mn.adr/dat_w/sel/we/cyc/stb to s. Return s.ack/s.err to mn only. The other master sees ack=0 and err=0.
- Release: in GNTn, when mn.cyc is sampled low:
  - prio is set to the other master.
  - If the other master's cyc is high in that same cycle, go directly to its GNT state (no IDLE bubble).
  - Otherwise go to IDLE.
- Grants are never preempted mid-cycle. Burst and back-to-back STB under one CYC stay with the owner.
- dat_r is broadcast to both masters. It is only valid when qualified by that master's ack.
- In IDLE, s.cyc, s.stb, s.we, s.adr, s.sel and s.dat_w are all 0.
- Reset, including mid-transfer, forces:
  - state = IDLE, prio = 0, watchdog count = 0.
  - All slave-side outputs and both masters' ack/err = 0 in the cycle after rst is sampled.
  - An abandoned slave ack that arrives later is not forwarded, because the state is IDLE.

## Timing
- Arbitration latency is 1 cycle. mn.cyc/stb rise at edge N, and s.cyc/stb rise after edge N+1.
- Data-phase latency is 0. s.ack passes combinationally to the owner in the same cycle.
- Handoff: owner drops cyc in cycle K. If the other master is requesting, it sees s.cyc high in cycle K+1.
- Maximum fairness wait for a requesting master is one complete CYC of the other master.

## Configuration
- WB_ARB_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) increments on each cycle with s.cyc & s.stb & ~s.ack & ~s.err.
  - It clears on ack, on err, or when s.stb is low.
  - On the cycle the count equals TIMEOUT_CYCLES-1:
    - The owner receives err=1 for that one cycle.
    - s.stb is forced to 0 for that cycle.
    - The counter clears.
  - Slave err is still passed through normally.
- WB_ARB_TIMEOUT_EN undefined: no counter is built, and err is pure pass-through from the slave.

## Structure
- Package wb_arb_pkg holds:
  - The typedef enum logic [1:0] for {IDLE, GNT0, GNT1}.
  - The localparam for the reset priority (0).
- Sub-module wb_arb_watchdog (parameter TIMEOUT_CYCLES):
  - Inputs: clk, rst, active, done.
  - Output: expire.
  - It is instantiated only under WB_ARB_TIMEOUT_EN.

## Test plan
- m0 single read to 0x0000_0010, slave acks in 2 cycles -> s.cyc rises 1 cycle after m0.cyc; m0.ack pulses once with slave data 0xDEAD_BEEF; m1.ack stays 0.
- m0 and m1 both raise cyc on the same edge after reset -> m0 granted first. After m0 drops cyc, m1 granted the next cycle. A following simultaneous request is granted to m0 (prio toggled back).
- m1 holds cyc through a 4-beat burst while m0 requests -> m0 is not granted until m1.cyc falls. m0 then sees s.cyc the following cycle with no IDLE cycle between.
- rst asserted while GNT1 is waiting for ack -> next cycle all s outputs are 0 and state is IDLE. A late slave ack is not seen by either master.
- With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, m0 write to a slave that never acks -> m0.err is 1 for exactly one cycle, 8 cycles after s.stb rose, and s.stb is 0 in that cycle. Without the macro, the cycle stays pending indefinitely.
- Slave returns err to m1 -> m1.err is high in the same cycle and m0.err stays 0.
